// File: rtl/arp_resolver.sv
// arp_resolver: resolves a destination IPv4 address to a MAC via table lookup, then ARP retries.
// Define ARP_RESOLVER_CACHE_EN to add a one-entry cache of the last resolved IP/MAC pair.
module arp_resolver #(
    parameter logic [23:0] P_TIMEOUT   = 24'd1_250_000,
    parameter int          P_MAX_RETRY = 3,
    parameter int          P_TBL_WDOG  = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_req_ip,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    output logic [31:0] o_seek_ip,
    output logic        o_seek_valid,
    input  logic [47:0] i_active_mac,
    input  logic        i_active_valid,
    output logic [31:0] o_arp_req_ip,
    output logic        o_arp_req_valid,
    input  logic        i_arp_req_ready,
    input  logic [31:0] i_updata_ip,
    input  logic [47:0] i_updata_mac,
    input  logic        i_updata_valid,
    output logic [47:0] o_dst_mac,
    output logic        o_dst_valid,
    output logic        o_dst_fail
);

    localparam logic [31:0] IP_ONES   = '1;
    localparam logic [47:0] MAC_ONES  = '1;
    localparam logic [2:0]  MAX_RETRY = 3'(P_MAX_RETRY);
    localparam logic [23:0] WDOG_LOAD = 24'(P_TBL_WDOG - 1);
    localparam logic [23:0] TMO_LOAD  = P_TIMEOUT - 24'd1;

    typedef enum logic [2:0] {
        IDLE, SEEK, WAIT_TBL, ARP_REQ, WAIT_REPLY, DONE, FAIL
    } state_t;

    state_t      state, state_n;
    logic [31:0] ip_r, ip_n;
    logic [47:0] mac_r, mac_n;
    logic [23:0] timer, timer_n;
    logic [2:0]  retry, retry_n;
    logic        accept;
    logic        reply_hit;

    assign accept    = i_req_valid && o_req_ready;
    assign reply_hit = i_updata_valid && (i_updata_ip == ip_r);

`ifdef ARP_RESOLVER_CACHE_EN
    logic        cache_valid;
    logic [31:0] cache_ip;
    logic [47:0] cache_mac;

    // A reply seen on the update bus is newer than a completion, so it wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cache_valid <= 1'b0;
            cache_ip    <= '0;
            cache_mac   <= '0;
        end else begin
            if (state == DONE && ip_r != IP_ONES) begin
                cache_valid <= 1'b1;
                cache_ip    <= ip_r;
                cache_mac   <= mac_r;
            end
            if (cache_valid && i_updata_valid && i_updata_ip == cache_ip)
                cache_mac <= i_updata_mac;
        end
    end
`endif

    always_comb begin
        state_n = state;
        ip_n    = ip_r;
        mac_n   = mac_r;
        timer_n = timer;
        retry_n = retry;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ip_n    = i_req_ip;
                    retry_n = '0;
                    if (i_req_ip == IP_ONES) begin
                        mac_n   = MAC_ONES;
                        state_n = DONE;
                    end
`ifdef ARP_RESOLVER_CACHE_EN
                    else if (cache_valid && i_req_ip == cache_ip) begin
                        mac_n   = cache_mac;
                        state_n = DONE;
                    end
`endif
                    else begin
                        state_n = SEEK;
                    end
                end
            end
            SEEK: begin
                timer_n = WDOG_LOAD;
                state_n = WAIT_TBL;
            end
            WAIT_TBL: begin
                if (i_active_valid && i_active_mac != MAC_ONES) begin
                    mac_n   = i_active_mac;
                    state_n = DONE;
                end else if (i_active_valid || timer == '0) begin
                    state_n = ARP_REQ;
                end else begin
                    timer_n = timer - 24'd1;
                end
            end
            ARP_REQ: begin
                if (reply_hit) begin
                    mac_n   = i_updata_mac;
                    state_n = DONE;
                end else if (i_arp_req_ready) begin
                    retry_n = retry + 3'd1;
                    timer_n = TMO_LOAD;
                    state_n = WAIT_REPLY;
                end
            end
            WAIT_REPLY: begin
                // Reply is tested before the timeout so a same-cycle reply wins.
                if (reply_hit) begin
                    mac_n   = i_updata_mac;
                    state_n = DONE;
                end else if (timer <= 24'd1) begin
                    state_n = (retry < MAX_RETRY) ? ARP_REQ : FAIL;
                end else begin
                    timer_n = timer - 24'd1;
                end
            end
            DONE:    state_n = IDLE;
            FAIL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            ip_r  <= '0;
            mac_r <= '0;
            timer <= '0;
            retry <= '0;
        end else begin
            state <= state_n;
            ip_r  <= ip_n;
            mac_r <= mac_n;
            timer <= timer_n;
            retry <= retry_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req_ready     <= 1'b0;
            o_seek_ip       <= '0;
            o_seek_valid    <= 1'b0;
            o_arp_req_ip    <= '0;
            o_arp_req_valid <= 1'b0;
            o_dst_mac       <= '0;
            o_dst_valid     <= 1'b0;
            o_dst_fail      <= 1'b0;
        end else begin
            o_req_ready     <= (state_n == IDLE);
            o_seek_ip       <= ip_n;
            o_seek_valid    <= (state_n == SEEK);
            o_arp_req_ip    <= ip_n;
            o_arp_req_valid <= (state_n == ARP_REQ);
            o_dst_valid     <= (state == DONE) || (state == FAIL);
            o_dst_fail      <= (state == FAIL);
            if (state == FAIL)
                o_dst_mac <= MAC_ONES;
            else if (state == DONE)
                o_dst_mac <= mac_r;
            else
                o_dst_mac <= '0;
        end
    end

endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver: randomized transactions against a rule-level model of resolution outcomes.
// Acts as ARP table, request transmitter and reply source; cache expectations follow ARP_RESOLVER_CACHE_EN.
module tb_arp_resolver;

    localparam logic [23:0] TMO  = 24'd100;
    localparam int          WDOG = 64;
    localparam int          MAXR = 3;
    localparam logic [31:0] IP10 = 32'hC0A8_010A;
    localparam logic [31:0] IP12 = 32'hC0A8_010C;
    localparam logic [31:0] BCST = 32'hFFFF_FFFF;
    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] i_req_ip = '0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] o_seek_ip;
    logic        o_seek_valid;
    logic [47:0] i_active_mac = '0;
    logic        i_active_valid = 1'b0;
    logic [31:0] o_arp_req_ip;
    logic        o_arp_req_valid;
    logic        i_arp_req_ready = 1'b0;
    logic [31:0] i_updata_ip = '0;
    logic [47:0] i_updata_mac = '0;
    logic        i_updata_valid = 1'b0;
    logic [47:0] o_dst_mac;
    logic        o_dst_valid;
    logic        o_dst_fail;

    arp_resolver #(.P_TIMEOUT(TMO), .P_MAX_RETRY(MAXR), .P_TBL_WDOG(WDOG)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_ip(i_req_ip), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .o_seek_ip(o_seek_ip), .o_seek_valid(o_seek_valid),
        .i_active_mac(i_active_mac), .i_active_valid(i_active_valid),
        .o_arp_req_ip(o_arp_req_ip), .o_arp_req_valid(o_arp_req_valid),
        .i_arp_req_ready(i_arp_req_ready),
        .i_updata_ip(i_updata_ip), .i_updata_mac(i_updata_mac), .i_updata_valid(i_updata_valid),
        .o_dst_mac(o_dst_mac), .o_dst_valid(o_dst_valid), .o_dst_fail(o_dst_fail)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model cache state
    logic        m_cv = 1'b0;
    logic [31:0] m_cip = '0;
    logic [47:0] m_cmac = '0;

    // observations of the last transaction
    bit          r_done;
    int          r_seeks, r_arps, r_acc, r_av, r_seek_cyc, r_first_arp, r_rep, r_dv;
    logic [47:0] r_mac;
    logic        r_fail;
    int          hs_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid     = 1'b0;
        i_req_ip        = '0;
        i_active_valid  = 1'b0;
        i_active_mac    = '0;
        i_arp_req_ready = 1'b0;
        i_updata_valid  = 1'b0;
        i_updata_ip     = '0;
        i_updata_mac    = '0;
    endtask

    function automatic logic [47:0] rnd_mac();
        return {16'($urandom), $urandom};
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_dst_valid", 64'(o_dst_valid), 64'd0);
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 64'(|{o_req_ready, o_seek_ip, o_seek_valid, o_arp_req_ip,
            o_arp_req_valid, o_dst_mac, o_dst_valid, o_dst_fail}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(o_req_ready), 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (o_dst_valid) chk("no_pulse_after_rst", 64'(o_dst_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        m_cv = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] ip, input int tbl_delay, input bit tbl_hit,
                           input logic [47:0] tbl_mac, input int ready_delay,
                           input int reply_on, input bit reply_in_req, input int reply_delay,
                           input logic [47:0] reply_mac, input bit junk,
                           input logic [47:0] junk_mac, input bit abort);
        int c, w, tbl_due, reply_due, junk_due;
        bit issued, arp_seen, stop;
        c = 0; w = 0; tbl_due = -1; reply_due = -1; junk_due = -1;
        issued = 0; arp_seen = 0; stop = 0;
        r_done = 0; r_seeks = 0; r_arps = 0; r_acc = -1; r_av = -1; r_seek_cyc = -1;
        r_first_arp = -1; r_rep = -1; r_dv = -1; r_mac = '0; r_fail = 1'b0;
        hs_q.delete();
        while (!r_done && !stop && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
            idle_inputs();
            if (o_dst_valid) begin
                r_done = 1; r_dv = c; r_mac = o_dst_mac; r_fail = o_dst_fail;
            end else begin
                if (!issued && o_req_ready) begin
                    i_req_valid = 1'b1; i_req_ip = ip; issued = 1; r_acc = c;
                end
                if (o_seek_valid) begin
                    r_seeks++;
                    r_seek_cyc = c;
                    if (tbl_delay > 0) tbl_due = c + tbl_delay;
                    chk("seek_ip", 64'(o_seek_ip), 64'(ip));
                end
                if (c == tbl_due) begin
                    i_active_valid = 1'b1;
                    i_active_mac   = tbl_hit ? tbl_mac : ONES;
                    r_av = c;
                end
                if (o_arp_req_valid) begin
                    if (!arp_seen) begin arp_seen = 1; r_first_arp = c; end
                    if (w == 0) chk("arp_ip", 64'(o_arp_req_ip), 64'(ip));
                    if (reply_in_req && r_arps + 1 == reply_on && w == 0) begin
                        i_updata_valid = 1'b1; i_updata_ip = ip; i_updata_mac = reply_mac;
                        r_rep = c;
                    end else if (w >= ready_delay) begin
                        i_arp_req_ready = 1'b1;
                        hs_q.push_back(c);
                        r_arps++;
                        w = 0;
                        if (!reply_in_req && r_arps == reply_on) reply_due = c + reply_delay;
                        if (junk && r_arps == 1) junk_due = c + 1;
                    end else begin
                        w++;
                    end
                end
                if (c == junk_due) begin
                    i_updata_valid = 1'b1; i_updata_ip = ip ^ 32'd1; i_updata_mac = junk_mac;
                end
                if (c == reply_due) begin
                    i_updata_valid = 1'b1; i_updata_ip = ip; i_updata_mac = reply_mac;
                    r_rep = c;
                end
                if (abort && r_arps > 0 && c >= hs_q[0] + 5) stop = 1;
            end
        end
    endtask

    task automatic do_txn(input logic [31:0] ip, input int tbl_delay, input bit tbl_hit,
                          input logic [47:0] tbl_mac, input int ready_delay,
                          input int reply_on, input bit reply_in_req, input int reply_delay,
                          input logic [47:0] reply_mac, input bit junk);
        logic [47:0] jm, e_mac;
        bit bcast, chit, thit, e_fail;
        int e_arps;
        jm = rnd_mac();
        bcast = (ip == BCST);
        chit = 0;
`ifdef ARP_RESOLVER_CACHE_EN
        chit = !bcast && m_cv && (m_cip == ip);
`endif
        thit = !bcast && !chit && tbl_delay > 0 && tbl_hit;
        e_arps = 0; e_fail = 0; e_mac = '0;
        run_txn(ip, tbl_delay, tbl_hit, tbl_mac, ready_delay, reply_on, reply_in_req,
                reply_delay, reply_mac, junk, jm, 1'b0);
        chk("done_in_bound", 64'(r_done), 64'd1);
        if (bcast || chit) begin
            chk("seek_count", 64'(r_seeks), 64'd0);
            e_mac = bcast ? ONES : m_cmac;
            chk("lat_accept", 64'(r_dv - r_acc), 64'd2);
        end else if (thit) begin
            chk("seek_count", 64'(r_seeks), 64'd1);
            e_mac = tbl_mac;
            chk("lat_table", 64'(r_dv - r_av), 64'd2);
        end else begin
            chk("seek_count", 64'(r_seeks), 64'd1);
            if (tbl_delay == 0)
                chk("wdog_lat", 64'(r_first_arp - r_seek_cyc), 64'(WDOG + 1));
            if (reply_on > 0) begin
                e_arps = reply_in_req ? reply_on - 1 : reply_on;
                e_mac  = reply_mac;
                chk("lat_reply", 64'(r_dv - r_rep), 64'd2);
            end else begin
                e_arps = MAXR;
                e_mac  = ONES;
                e_fail = 1;
                if (hs_q.size() > 0)
                    chk("lat_fail", 64'(r_dv - hs_q[$]), 64'(int'(TMO) + 1));
            end
            for (int i = 1; i < hs_q.size(); i++)
                chk("arp_spacing", 64'(hs_q[i] - hs_q[i-1]), 64'(int'(TMO) + ready_delay));
        end
        chk("arp_count", 64'(r_arps), 64'(e_arps));
        if (e_arps == 0 && !(reply_in_req && reply_on == 1))
            chk("no_arp_valid", 64'(r_first_arp < 0), 64'd1);
        chk("dst_mac", 64'(r_mac), 64'(e_mac));
        chk("dst_fail", 64'(r_fail), 64'(e_fail));
        @(posedge clk);
        #1;
        chk("pulse_width", 64'(o_dst_valid), 64'd0);
        if (junk && e_arps >= 1 && m_cv && m_cip == (ip ^ 32'd1)) m_cmac = jm;
        if (!bcast && !e_fail) begin
            m_cv = 1'b1; m_cip = ip; m_cmac = e_mac;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] pool [4];
        pool[0] = 32'hC0A8_010A; pool[1] = 32'hC0A8_010B;
        pool[2] = 32'hC0A8_010C; pool[3] = 32'hC0A8_010D;
        #2;
        reset_dut();
        // table hit, then the same request again (cache path when enabled)
        do_txn(IP10, 3, 1, 48'h0011_2233_4455, 0, 0, 0, 0, '0, 0);
        do_txn(IP10, 3, 1, 48'h0011_2233_4455, 0, 0, 0, 0, '0, 0);
        reset_dut();
        do_txn(IP10, 4, 0, '0, 5, 1, 0, 20, 48'hAABB_CCDD_EE01, 0);
        reset_dut();
        do_txn(IP10, 2, 0, '0, 0, 1, 0, int'(TMO) - 1, 48'h1234_5678_9ABC, 1);
        reset_dut();
        do_txn(IP10, 5, 0, '0, 0, 0, 0, 0, '0, 0);
        do_txn(BCST, 3, 1, 48'h0011_2233_4455, 0, 0, 0, 0, '0, 0);
        run_txn(IP12, 0, 0, '0, 0, 0, 0, 0, '0, 0, '0, 1'b1);
        chk("abort_not_done", 64'(r_done), 64'd0);
        reset_dut();
        for (int n = 0; n < 40; n++) begin
            int kind, rd, ron, rdl;
            logic [31:0] ip;
            kind = $urandom_range(0, 5);
            ip   = (kind == 0) ? BCST : pool[$urandom_range(0, 3)];
            rd   = (kind == 4) ? 0 : $urandom_range(0, 5);
            ron  = (kind == 4) ? 0 : $urandom_range(1, 3);
            rdl  = $urandom_range(2, int'(TMO) - 1);
            do_txn(ip, (kind == 3) ? 0 : $urandom_range(1, 20), kind == 1, rnd_mac(),
                   rd, ron, kind == 5, rdl, rnd_mac(), 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/arp_resolver.md
ARP_RESOLVER -- requirements
Module: arp_resolver

Interface
REQ-001 SHALL have parameter P_TIMEOUT, default 24'd1_250_000: cycles to wait for an ARP reply before retrying (10 ms at 125 MHz).
REQ-002 SHALL have parameter P_MAX_RETRY, default 3: ARP requests sent before declaring failure.
REQ-003 SHALL have parameter P_TBL_WDOG, default 64: cycles to wait for an ARP table answer.
REQ-004 Ports, in this order:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_ip  in  32  destination IP to resolve.
- i_req_valid  in  1  request strobe; accepted only when o_req_ready=1.
- o_req_ready  out  1  high in IDLE only.
- o_seek_ip  out  32  lookup IP to the ARP table.
- o_seek_valid  out  1  one-cycle lookup strobe.
- i_active_mac  in  48  table answer; 48'hFFFF_FFFF_FFFF means miss.
- i_active_valid  in  1  table answer strobe.
- o_arp_req_ip  out  32  target IP for the ARP request transmitter.
- o_arp_req_valid  out  1  held high until i_arp_req_ready.
- i_arp_req_ready  in  1  transmitter accepts the request.
- i_updata_ip  in  32  IP of a received ARP reply, snooped from the table-update bus.
- i_updata_mac  in  48  MAC of a received ARP reply.
- i_updata_valid  in  1  reply strobe.
- o_dst_mac  out  48  resolved MAC.
- o_dst_valid  out  1  one-cycle result strobe.
- o_dst_fail  out  1  one-cycle failure strobe; o_dst_mac=all-ones.

Function
REQ-005 SHALL implement FSM states IDLE, SEEK, WAIT_TBL, ARP_REQ, WAIT_REPLY, DONE, FAIL.
REQ-006 IDLE: on i_req_valid, SHALL register i_req_ip, clear the retry count, and go to SEEK.
REQ-007 If i_req_ip is 32'hFFFF_FFFF, SHALL skip the lookup and go to DONE with MAC all-ones.
REQ-008 SEEK: SHALL assert o_seek_valid for exactly one cycle with o_seek_ip set to the registered IP, then go to WAIT_TBL.
REQ-009 WAIT_TBL: on i_active_valid with a non-all-ones MAC, SHALL capture the MAC and go to DONE.
REQ-010 WAIT_TBL: on a miss, or when P_TBL_WDOG cycles pass with no answer, SHALL go to ARP_REQ.
REQ-011 ARP_REQ: SHALL drive o_arp_req_ip and o_arp_req_valid until i_arp_req_ready is high in the same cycle, then increment the retry count, load the timeout counter, and go to WAIT_REPLY.
REQ-012 WAIT_REPLY: on i_updata_valid with i_updata_ip equal to the registered IP, SHALL capture i_updata_mac and go to DONE; non-matching replies are ignored.
REQ-013 WAIT_REPLY: on timeout with retry count < P_MAX_RETRY, SHALL go to ARP_REQ; on timeout with retry count = P_MAX_RETRY, SHALL go to FAIL.
REQ-014 If a matching reply and the timeout occur in the same cycle, the reply SHALL win.
REQ-015 A matching i_updata_valid during ARP_REQ SHALL also complete the request and go to DONE.
REQ-016 DONE: SHALL pulse o_dst_valid for one cycle with o_dst_mac, then return to IDLE.
REQ-017 FAIL: SHALL pulse o_dst_fail and o_dst_valid together, with o_dst_mac all-ones, then return to IDLE.
REQ-018 All outputs SHALL be registered.
REQ-019 Latency on a table hit: o_dst_valid SHALL assert 2 cycles after i_active_valid.
REQ-020 The timeout counter SHALL be 24 bits wide and count down to zero without wrap-around; the retry counter SHALL be 3 bits wide.

Reset
REQ-021 While i_rst_n=0, SHALL enter IDLE immediately and hold all outputs at 0, except o_req_ready, which deasserts during reset and asserts on the first clock after release.
REQ-022 Reset asserted mid-operation SHALL abort the request with no result pulse.

Configuration
REQ-023 With macro ARP_RESOLVER_CACHE_EN defined, SHALL keep a one-entry cache holding the last IP/MAC pair that completed via DONE, excluding the broadcast case.
- A request for the cached IP SHALL go directly to DONE, giving o_dst_valid 2 cycles after acceptance with no o_seek_valid.
- A matching i_updata_valid SHALL refresh the cached MAC at any time.
- Reset SHALL invalidate the cache.
REQ-024 Without ARP_RESOLVER_CACHE_EN, no cache logic SHALL exist and every request SHALL perform SEEK.

Verification
REQ-025 Table hit: request 192.168.1.10 and answer with MAC 00:11:22:33:44:55 -> o_dst_valid with that MAC, no o_arp_req_valid.
REQ-026 Miss then reply: table answers all-ones, i_arp_req_ready is held low for 5 cycles, then an update for 192.168.1.10 carries MAC AA:BB:CC:DD:EE:01 -> exactly one ARP request and o_dst_mac = AA:BB:CC:DD:EE:01.
REQ-027 No reply, with P_TIMEOUT=100 -> 3 ARP requests spaced 100 cycles apart, then o_dst_fail with MAC all-ones.
REQ-028 Non-matching update for 192.168.1.11 followed by a matching reply on the exact timeout cycle -> the non-matching update is ignored, DONE is reached, and the retry count stays 1.
REQ-029 Broadcast request 255.255.255.255 -> result all-ones with no seek; reset asserted in WAIT_REPLY -> IDLE with no result pulse.
REQ-030 With ARP_RESOLVER_CACHE_EN defined, repeat the REQ-025 request -> second result in 2 cycles with no o_seek_valid.
